// File: rtl/vscale_hpm_counters_pkg.sv
// vscale_hpm_counters_pkg: shared widths, CSR encodings and HPM defaults for the counter block
package vscale_hpm_counters_pkg;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH = 3;
    localparam int XPR_LEN = 32;
    localparam int PRV_WIDTH = 2;
    localparam int HTIF_PCR_WIDTH = 64;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET = 3'd6;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_CNT_BASE = 12'hB03;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_CNT_H_BASE = 12'hB83;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_EVT_BASE = 12'h323;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_INHIBIT_ADDR = 12'h320;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_OVF_ADDR = 12'h7C0;
    localparam logic [CSR_ADDR_WIDTH-1:0] HPM_OVF_IE_ADDR = 12'h7C1;
    typedef enum logic {HPM_FSM_IDLE, HPM_FSM_WAIT} hpm_fsm_t;
    function automatic logic [XPR_LEN-1:0] csr_wr_val(input logic [CSR_CMD_WIDTH-1:0] cmd,
                                                      input logic [XPR_LEN-1:0] old, src);
        return cmd == CSR_SET ? old | src : cmd == CSR_CLEAR ? old & ~src : src;
    endfunction
endpackage

// File: rtl/vscale_hpm_counters_if.sv
// vscale_hpm_counters_if: host request/response port of the HPM block
interface vscale_hpm_counters_if;
    import vscale_hpm_counters_pkg::*;
    logic req_valid, req_ready, req_rw;
    logic [CSR_ADDR_WIDTH-1:0] req_addr;
    logic [HTIF_PCR_WIDTH-1:0] req_data, resp_data;
    logic resp_valid, resp_ready;
    modport master (output req_valid, req_rw, req_addr, req_data, resp_ready,
                    input req_ready, resp_valid, resp_data);
    modport slave (input req_valid, req_rw, req_addr, req_data, resp_ready,
                   output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/vscale_hpm_counter.sv
// vscale_hpm_counter: one event counter with selectable event, inhibit, split-word write and wrap pulse
module vscale_hpm_counter
    import vscale_hpm_counters_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_EVENTS = 8,
    parameter int SEL_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [SEL_W-1:0] sel,
    input  logic inhibit,
    input  logic wen_lo,
    input  logic wen_hi,
    input  logic [XPR_LEN-1:0] wdata,
    output logic [CNT_WIDTH-1:0] count,
    output logic wrap
);
    localparam int EV_W = 1 << SEL_W;
    localparam int HI_W = CNT_WIDTH - XPR_LEN;
    // zero padding makes selectors beyond NUM_EVENTS count nothing
    logic [EV_W-1:0] ev_pad;
    logic inc;
    assign ev_pad = EV_W'(events);
    assign inc = ev_pad[sel] && !inhibit;
    assign wrap = inc && &count && !wen_lo && !wen_hi;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (wen_lo) count[XPR_LEN-1:0] <= wdata;
        else if (wen_hi) count[CNT_WIDTH-1:XPR_LEN] <= wdata[HI_W-1:0];
        else count <= count + CNT_WIDTH'(inc);
    end
endmodule

// File: rtl/vscale_hpm_counters.sv
// vscale_hpm_counters: machine-mode performance counters behind the CSR port and a host port
module vscale_hpm_counters
    import vscale_hpm_counters_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int CNT_WIDTH = 64,
    parameter int NUM_EVENTS = 8,
    parameter logic [CSR_ADDR_WIDTH-1:0] CNT_BASE = HPM_CNT_BASE,
    parameter logic [CSR_ADDR_WIDTH-1:0] CNT_H_BASE = HPM_CNT_H_BASE,
    parameter logic [CSR_ADDR_WIDTH-1:0] EVT_BASE = HPM_EVT_BASE,
    parameter logic [CSR_ADDR_WIDTH-1:0] INHIBIT_ADDR = HPM_INHIBIT_ADDR,
    parameter logic [CSR_ADDR_WIDTH-1:0] OVF_ADDR = HPM_OVF_ADDR,
    parameter logic [CSR_ADDR_WIDTH-1:0] OVF_IE_ADDR = HPM_OVF_IE_ADDR
) (
    input  logic clk,
    input  logic reset,
    input  logic [CSR_ADDR_WIDTH-1:0] addr,
    input  logic [CSR_CMD_WIDTH-1:0] cmd,
    input  logic [XPR_LEN-1:0] wdata,
    input  logic [PRV_WIDTH-1:0] prv,
    output logic [XPR_LEN-1:0] csr_rdata,
    output logic hit,
    output logic illegal_access,
    input  logic [NUM_EVENTS-1:0] events,
    output logic ovf_irq,
    vscale_hpm_counters_if.slave host
);
    localparam int N = NUM_COUNTERS;
    localparam int SEL_W = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
    logic [CNT_WIDTH-1:0] count [N];
    logic [SEL_W-1:0] sel [N];
    logic [N-1:0] inhibit, ovf, ovf_ie, wrap, ovf_next, ovf_ie_next;
    hpm_fsm_t state, state_next;
    logic sys_wen, host_fire, wen;
    logic [CSR_ADDR_WIDTH-1:0] w_addr;
    logic [XPR_LEN-1:0] w_val;
    logic [HTIF_PCR_WIDTH-1:0] resp_data;
    logic unused_host_bits;

    function automatic logic [XPR_LEN-1:0] rd(input logic [CSR_ADDR_WIDTH-1:0] a);
        logic [XPR_LEN-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            if (a == CNT_BASE + 12'(i)) r = count[i][XPR_LEN-1:0];
            if (a == CNT_H_BASE + 12'(i)) r = XPR_LEN'(count[i][CNT_WIDTH-1:XPR_LEN]);
            if (a == EVT_BASE + 12'(i)) r = XPR_LEN'(sel[i]);
        end
        if (a == INHIBIT_ADDR) r = XPR_LEN'(inhibit);
        if (a == OVF_ADDR) r = XPR_LEN'(ovf);
        if (a == OVF_IE_ADDR) r = XPR_LEN'(ovf_ie);
        return r;
    endfunction

    function automatic logic decodes(input logic [CSR_ADDR_WIDTH-1:0] a);
        logic d = a == INHIBIT_ADDR || a == OVF_ADDR || a == OVF_IE_ADDR;
        for (int i = 0; i < N; i++)
            d |= a == CNT_BASE + 12'(i) || a == CNT_H_BASE + 12'(i) || a == EVT_BASE + 12'(i);
        return d;
    endfunction

    assign csr_rdata = rd(addr);
    assign hit = decodes(addr);
    assign illegal_access = cmd[2] && hit && ((|cmd[1:0] && addr[11:10] == 2'b11) || addr[9:8] > prv);
    assign sys_wen = cmd[2] && |cmd[1:0] && hit && !illegal_access;
    assign host.req_ready = state == HPM_FSM_IDLE && !sys_wen;
    assign host.resp_valid = state == HPM_FSM_WAIT;
    assign host.resp_data = resp_data;
    assign host_fire = host.req_valid && host.req_ready;
    // one shared write port: the host only gets it when the pipeline is not writing
    assign wen = sys_wen || (host_fire && host.req_rw);
    assign w_addr = sys_wen ? addr : host.req_addr;
    assign w_val = csr_wr_val(sys_wen ? cmd : CSR_WRITE, rd(w_addr), sys_wen ? wdata : host.req_data[XPR_LEN-1:0]);
    assign unused_host_bits = ^host.req_data[HTIF_PCR_WIDTH-1:XPR_LEN];

    for (genvar i = 0; i < N; i++) begin : g_cnt
        vscale_hpm_counter #(.CNT_WIDTH(CNT_WIDTH), .NUM_EVENTS(NUM_EVENTS), .SEL_W(SEL_W)) u_cnt (
            .clk(clk),
            .reset(reset),
            .events(events),
            .sel(sel[i]),
            .inhibit(inhibit[i]),
            .wen_lo(wen && w_addr == CNT_BASE + 12'(i)),
            .wen_hi(wen && w_addr == CNT_H_BASE + 12'(i)),
            .wdata(w_val),
            .count(count[i]),
            .wrap(wrap[i])
        );
    end

    // hardware overflow wins over a simultaneous software write of the same bit
    assign ovf_next = (wen && w_addr == OVF_ADDR ? w_val[N-1:0] : ovf) | wrap;
    assign ovf_ie_next = wen && w_addr == OVF_IE_ADDR ? w_val[N-1:0] : ovf_ie;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) sel[i] <= '0;
            inhibit <= '1;
            ovf <= '0;
            ovf_ie <= '0;
            ovf_irq <= 1'b0;
            resp_data <= '0;
        end else begin
            for (int i = 0; i < N; i++) if (wen && w_addr == EVT_BASE + 12'(i)) sel[i] <= w_val[SEL_W-1:0];
            if (wen && w_addr == INHIBIT_ADDR) inhibit <= w_val[N-1:0];
            ovf <= ovf_next;
            ovf_ie <= ovf_ie_next;
            ovf_irq <= |(ovf_next & ovf_ie_next);
            if (host_fire) resp_data <= HTIF_PCR_WIDTH'(rd(host.req_addr));
        end
    end

    always_ff @(posedge clk) state <= reset ? HPM_FSM_IDLE : state_next;

    always_comb begin
        state_next = state;
        state_next = state == HPM_FSM_IDLE ? (host_fire ? HPM_FSM_WAIT : HPM_FSM_IDLE)
                                           : (host.resp_ready ? HPM_FSM_IDLE : HPM_FSM_WAIT);
    end
endmodule

// File: tb/tb_vscale_hpm_counters.sv
// tb_vscale_hpm_counters: directed stimulus checked every cycle against a behavioural model
module tb_vscale_hpm_counters;
    logic clk = 1'b0, reset = 1'b1;
    logic [11:0] addr = '0;
    logic [2:0] cmd = '0;
    logic [31:0] wdata = '0;
    logic [1:0] prv = 2'd3;
    logic [7:0] events = '0;
    logic [31:0] csr_rdata;
    logic hit, illegal_access, ovf_irq;
    int total = 0, bad = 0;

    vscale_hpm_counters_if host();
    vscale_hpm_counters dut (
        .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .wdata(wdata), .prv(prv),
        .csr_rdata(csr_rdata), .hit(hit), .illegal_access(illegal_access),
        .events(events), .ovf_irq(ovf_irq), .host(host)
    );

    always #5 clk = ~clk;

    longint unsigned m_cnt [4];
    int m_sel [4];
    bit [3:0] m_inh, m_ovf, m_ie;
    bit m_irq, m_wait, m_live;
    logic [63:0] m_resp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [11:0] a);
        for (int i = 0; i < 4; i++) begin
            if (int'(a) == 'hB03 + i) return m_cnt[i][31:0];
            if (int'(a) == 'hB83 + i) return m_cnt[i][63:32];
            if (int'(a) == 'h323 + i) return 32'(m_sel[i]);
        end
        if (a == 12'h320) return {28'b0, m_inh};
        if (a == 12'h7C0) return {28'b0, m_ovf};
        if (a == 12'h7C1) return {28'b0, m_ie};
        return 32'b0;
    endfunction

    function automatic bit m_hit(input logic [11:0] a);
        return (a >= 12'hB03 && a < 12'hB07) || (a >= 12'hB83 && a < 12'hB87) ||
               (a >= 12'h323 && a < 12'h327) || a == 12'h320 || a == 12'h7C0 || a == 12'h7C1;
    endfunction

    function automatic bit m_illegal();
        return cmd[2] && m_hit(addr) && ((cmd[1:0] != 0 && addr[11:10] == 2'b11) || addr[9:8] > prv);
    endfunction

    function automatic bit m_sys_wen();
        return cmd[2] && cmd[1:0] != 0 && m_hit(addr) && !m_illegal();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_sel[i] = 0;
            end
            m_inh = 4'hF; m_ovf = 0; m_ie = 0; m_irq = 0; m_wait = 0; m_resp = 0; m_live = 1;
        end else if (m_live) begin
            bit sw, hf, w;
            logic [11:0] wa;
            logic [31:0] wv, src, old;
            bit [3:0] hw, nov, nie;
            sw = m_sys_wen();
            hf = !m_wait && !sw && host.req_valid;
            w = sw || (hf && host.req_rw);
            wa = sw ? addr : host.req_addr;
            src = sw ? wdata : host.req_data[31:0];
            old = m_rd(wa);
            wv = (sw && cmd == 3'd6) ? (old | src) : (sw && cmd == 3'd7) ? (old & ~src) : src;
            if (hf) m_resp = {32'b0, m_rd(host.req_addr)};
            hw = 0;
            for (int i = 0; i < 4; i++) begin
                if (w && int'(wa) == 'hB03 + i) m_cnt[i] = {m_cnt[i][63:32], wv};
                else if (w && int'(wa) == 'hB83 + i) m_cnt[i] = {wv, m_cnt[i][31:0]};
                else if (!m_inh[i] && events[m_sel[i]]) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) hw[i] = 1;
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            for (int i = 0; i < 4; i++) if (w && int'(wa) == 'h323 + i) m_sel[i] = int'(wv % 8);
            if (w && wa == 12'h320) m_inh = wv[3:0];
            nov = ((w && wa == 12'h7C0) ? wv[3:0] : m_ovf) | hw;
            nie = (w && wa == 12'h7C1) ? wv[3:0] : m_ie;
            m_ovf = nov; m_ie = nie; m_irq = |(nov & nie);
            m_wait = m_wait ? !host.resp_ready : hf;
        end
    end

    always @(negedge clk) if (m_live) begin
        chk("rdata", csr_rdata, m_rd(addr));
        chk("hit", hit, m_hit(addr));
        chk("illegal", illegal_access, m_illegal());
        chk("irq", ovf_irq, m_irq);
        chk("req_ready", host.req_ready, !m_wait && !m_sys_wen());
        chk("resp_valid", host.resp_valid, m_wait);
        chk("resp_data", host.resp_data, m_resp);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pw(input logic [11:0] a, input logic [2:0] c, input logic [31:0] d);
        addr = a; cmd = c; wdata = d;
        step();
        cmd = 3'd4;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        addr = a; cmd = 3'd4;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    initial begin
        host.req_valid = 0; host.req_rw = 0; host.req_addr = '0; host.req_data = '0; host.resp_ready = 0;
        step(); step();
        reset = 0;
        rd_chk("inh_reset", 12'h320, 32'hF);
        chk("irq_reset", ovf_irq, 0);
        rd_chk("cnt0_reset", 12'hB03, 0);
        // count five selected events
        pw(12'h320, 3'd5, 0);
        pw(12'h323, 3'd5, 2);
        events = 8'h04;
        repeat (5) step();
        events = 0;
        rd_chk("cnt0_five", 12'hB03, 5);
        for (int i = 1; i < 4; i++) rd_chk("cnt_other_zero", 12'(12'hB03 + i), 0);
        // wrap from all-ones
        pw(12'hB83, 3'd5, 32'hFFFF_FFFF);
        pw(12'hB03, 3'd5, 32'hFFFF_FFFE);
        pw(12'h7C1, 3'd5, 1);
        events = 8'h04;
        step();
        chk("irq_before_wrap", ovf_irq, 0);
        step();
        events = 0;
        chk("irq_after_wrap", ovf_irq, 1);
        rd_chk("cnt0_wrapped", 12'hB03, 0);
        rd_chk("cnt0h_wrapped", 12'hB83, 0);
        rd_chk("ovf_set", 12'h7C0, 1);
        // write beats the simultaneous increment
        pw(12'hB83, 3'd5, 5);
        addr = 12'hB03; cmd = 3'd5; wdata = 7; events = 8'h04;
        step();
        events = 0; cmd = 3'd4;
        rd_chk("cnt0_write_wins", 12'hB03, 7);
        rd_chk("cnt0h_held", 12'hB83, 5);
        pw(12'h320, 3'd6, 2);
        rd_chk("inh_set", 12'h320, 2);
        pw(12'h320, 3'd7, 2);
        rd_chk("inh_clear", 12'h320, 0);
        // user-mode write is refused
        prv = 0; addr = 12'hB03; cmd = 3'd5; wdata = 99;
        #1 chk("illegal_user", illegal_access, 1);
        step();
        prv = 3; cmd = 3'd4;
        #1 chk("legal_machine", illegal_access, 0);
        rd_chk("cnt0_kept", 12'hB03, 7);
        // host clears ovf while counter 1 overflows
        pw(12'h324, 3'd5, 2);
        pw(12'hB84, 3'd5, 32'hFFFF_FFFF);
        pw(12'hB04, 3'd5, 32'hFFFF_FFFF);
        cmd = 0;
        host.req_valid = 1; host.req_rw = 1; host.req_addr = 12'h7C0; host.req_data = 0; events = 8'h04;
        #1 chk("host_ready", host.req_ready, 1);
        step();
        host.req_valid = 0; events = 0;
        chk("host_resp_prewrite", host.resp_data, 64'h1);
        step();
        chk("host_resp_held", host.resp_valid, 1);
        rd_chk("ovf_hw_wins", 12'h7C0, 2);
        host.resp_ready = 1;
        step();
        host.resp_ready = 0;
        chk("host_resp_done", host.resp_valid, 0);
        // pipeline write blocks the host for one cycle, then reset drops the response
        host.req_valid = 1; host.req_rw = 0; host.req_addr = 12'hB83;
        addr = 12'h324; cmd = 3'd5; wdata = 3;
        #1 chk("host_blocked", host.req_ready, 0);
        step();
        cmd = 3'd4;
        #1 chk("host_unblocked", host.req_ready, 1);
        step();
        host.req_valid = 0;
        chk("host_wait", host.resp_valid, 1);
        chk("host_read_cnt0h", host.resp_data, 64'h5);
        reset = 1;
        step();
        reset = 0;
        chk("resp_dropped", host.resp_valid, 0);
        step();
        rd_chk("inh_rereset", 12'h320, 32'hF);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
